// File: rtl/core_pkg.sv
// Shared rename-stage types: physical register ID width, register counts and
// the free-list controller state encoding.
package core_pkg;
  localparam int PREG_W   = 6;
  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;

  typedef logic [PREG_W-1:0] preg_id_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } fl_state_t;
endpackage

// File: rtl/free_list_if.sv
// Handshake bundle between the free list, the FRAT (allocation side) and the
// RRAT (retirement side), plus the flush and the sticky error flag.
interface free_list_if;
  import core_pkg::*;

  logic     SYS;
  logic     Shift_IN_FRAT;
  preg_id_t RegID_OUT_FRAT;
  logic     STALL_OUT_FRAT;
  logic     commit_IN_RRAT;
  logic     free_IN_RRAT;
  preg_id_t RegID_IN_RRAT;
  logic     overflow_ERR;

  modport slave (
    input  SYS, Shift_IN_FRAT, commit_IN_RRAT, free_IN_RRAT, RegID_IN_RRAT,
    output RegID_OUT_FRAT, STALL_OUT_FRAT, overflow_ERR
  );

  modport master (
    output SYS, Shift_IN_FRAT, commit_IN_RRAT, free_IN_RRAT, RegID_IN_RRAT,
    input  RegID_OUT_FRAT, STALL_OUT_FRAT, overflow_ERR
  );
endinterface

// File: rtl/free_list_mem.sv
// Circular storage for free physical register IDs: one synchronous write
// port, one asynchronous read port so the head entry falls through.
module free_list_mem
  import core_pkg::*;
#(
  parameter int DEPTH = NUM_PREG - NUM_AREG,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  preg_id_t      wdata_i,
  input  logic [AW-1:0] raddr_i,
  output preg_id_t      rdata_o
);

  preg_id_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/free_list.sv
// Physical-register free list with committed-head checkpoint for flush rollback.
// Optional `FREE_LIST_BYPASS_EN: on an empty list a same-cycle freed ID is granted directly.
module free_list
  import core_pkg::*;
#(
  parameter int DEPTH = NUM_PREG - NUM_AREG
) (
  input  logic        CLK,
  input  logic        RESET,
  free_list_if.slave  fl
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  fl_state_t state_q, state_d;
  ptr_t      head_q, head_d;
  ptr_t      chead_q, chead_d;
  ptr_t      tail_q, tail_d;
  ptr_t      init_cnt_q, init_cnt_d;
  logic      ovf_q, ovf_d;

  logic          we;
  logic [AW-1:0] waddr;
  preg_id_t      wdata;
  preg_id_t      rd_data;
  ptr_t          count;
  logic          empty;
  logic          full;
  logic          stall;
  preg_id_t      id_out;

  free_list_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (CLK),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (head_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  // Wrap bits make tail-head an exact occupancy in 0..DEPTH.
  assign count = tail_q - head_q;
  assign empty = (count == '0);
  assign full  = (count == ptr_t'(DEPTH));

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    chead_d    = chead_q;
    tail_d     = tail_q;
    init_cnt_d = init_cnt_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    waddr      = tail_q[AW-1:0];
    wdata      = fl.RegID_IN_RRAT;
    stall      = 1'b1;
    id_out     = '0;

    case (state_q)
      INIT: begin
        we         = 1'b1;
        wdata      = preg_id_t'(NUM_AREG) + PREG_W'(init_cnt_q);
        tail_d     = tail_q + 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ptr_t'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end

      RUN, RECOVER: begin
        if (state_q == RUN) begin
          stall  = empty;
          id_out = rd_data;
`ifdef FREE_LIST_BYPASS_EN
          if (empty && fl.free_IN_RRAT) begin
            stall  = 1'b0;
            id_out = fl.RegID_IN_RRAT;
          end
`endif
        end

        // Retirement is non-speculative: applied even in flush/recovery cycles.
        if (fl.free_IN_RRAT) begin
          if (!full) begin
            we     = 1'b1;
            tail_d = tail_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end

        if (fl.commit_IN_RRAT) begin
          if (chead_q != head_q) begin
            chead_d = chead_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end

        if (fl.SYS) begin
          head_d  = chead_d;
          state_d = RECOVER;
        end else if (state_q == RECOVER) begin
          state_d = RUN;
        end else if (fl.Shift_IN_FRAT && !stall) begin
          head_d = head_q + 1'b1;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= INIT;
      head_q     <= '0;
      chead_q    <= '0;
      tail_q     <= '0;
      init_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      chead_q    <= chead_d;
      tail_q     <= tail_d;
      init_cnt_q <= init_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign fl.RegID_OUT_FRAT = id_out;
  assign fl.STALL_OUT_FRAT = stall;
  assign fl.overflow_ERR   = ovf_q;

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
Physical-register free list and allocation controller for the rename stage of the out-of-order core.
- Owns all currently unmapped physical register IDs.
- Hands one ID per cycle to the FRAT on its shift request.
- Reclaims IDs freed by the RRAT at retirement.
- Rolls back speculative allocations on a SYS flush using a committed-head checkpoint.

Parameters:
- PREG_W, 6, width of a physical register ID
- NUM_PREG, 64, total physical registers
- NUM_AREG, 32, architectural registers (IDs 0..31 are mapped at reset)
- DEPTH, NUM_PREG-NUM_AREG (32), free list capacity; power of two

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- SYS  in  1  flush; discard speculative allocations
- Shift_IN_FRAT  in  1  FRAT consumes the presented ID this cycle
- RegID_OUT_FRAT  out  PREG_W  next free physical ID
- STALL_OUT_FRAT  out  1  no ID available; FRAT must hold
- commit_IN_RRAT  in  1  one previously allocated ID retired (advances committed head)
- free_IN_RRAT  in  1  return an ID to the list
- RegID_IN_RRAT  in  PREG_W  ID being returned
- overflow_ERR  out  1  sticky protocol-error flag

Behaviour:
- Storage:
  - DEPTH x PREG_W circular array.
  - Pointers head (alloc), chead (committed head) and tail (write), each log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - count = tail-head. empty: count==0. full: count==DEPTH.
- FSM states: INIT, RUN, RECOVER.
- Reset (RESET==0 at a CLK edge):
  - state=INIT; head=chead=tail=0; init counter=0; overflow_ERR=0.
  - Outputs: STALL_OUT_FRAT=1, RegID_OUT_FRAT=0.
  - Reset mid-operation discards all contents and restarts INIT.
- INIT:
  - Each cycle writes mem[i]=NUM_AREG+i and increments tail, for i=0..DEPTH-1.
  - After DEPTH cycles: transition to RUN; count==DEPTH.
  - STALL=1 throughout; SYS, Shift, commit and free are ignored.
- RUN:
  - RegID_OUT_FRAT = mem[head] (fall-through, combinational).
  - STALL_OUT_FRAT = empty.
  - Shift && !STALL: head+=1 next cycle. Shift while stalled is ignored.
  - free_IN_RRAT && !full: mem[tail]=RegID_IN_RRAT, tail+=1.
  - free when full: write dropped, overflow_ERR=1.
  - Freed ID becomes visible the following cycle. Free on empty keeps STALL=1 this cycle.
  - commit_IN_RRAT: chead+=1 if chead!=head. Otherwise ignored and overflow_ERR=1.
  - Simultaneous Shift, free and commit are all applied independently in the same cycle.
- SYS in RUN:
  - Next cycle: head = chead + (commit this cycle ? 1 : 0).
  - Shift in the SYS cycle is ignored.
  - free/commit in the SYS cycle are still applied, because retirement is non-speculative.
  - State -> RECOVER.
- RECOVER:
  - Exactly 1 cycle; STALL=1; Shift ignored; free/commit applied as in RUN.
  - Then -> RUN.
  - SYS during RECOVER re-applies the rollback and stays in RECOVER one more cycle.
- overflow_ERR is cleared only by reset.
- Latency: allocation is 0-cycle (ID valid in the same cycle as Shift). Free-to-available is 1 cycle.

Optional Feature:
- Macro: FREE_LIST_BYPASS_EN.
- Defined, in RUN only, when empty && free_IN_RRAT:
  - RegID_OUT_FRAT = RegID_IN_RRAT and STALL_OUT_FRAT=0.
  - If Shift is also asserted, tail and head both increment and the entry is written anyway.
- Undefined: no bypass; STALL=1 when empty regardless of a same-cycle free.

Decomposition:
- Shared package core_pkg:
  - PREG_W, NUM_PREG, NUM_AREG constants.
  - preg_id_t typedef.
  - fl_state_t enum {INIT, RUN, RECOVER}.
  - Reused by FRAT, busybits and RRAT.
- One natural sub-module: free_list_mem
  - DEPTH x PREG_W array.
  - One synchronous write port, one asynchronous read port.
  - Control and pointers stay in free_list.

Test Plan:
- Hold RESET=0 for 2 cycles, release: STALL=1 for 32 cycles, then RegID_OUT_FRAT=32, STALL=0.
- After init, Shift for 3 cycles: IDs 32, 33, 34 presented; then RegID_OUT_FRAT=35.
- Allocate all 32, then Shift again: STALL=1 and head unchanged. Free ID 5: next cycle RegID_OUT_FRAT=5, STALL=0.
- Allocate 32..35, commit once, assert SYS: one stall cycle, then RegID_OUT_FRAT=33.
- Free ID 7 while full: overflow_ERR=1 and stays set, contents unchanged. Commit with chead==head also sets it.
- Drop RESET at init cycle 10: restart, 32 fresh init cycles, first ID=32. With FREE_LIST_BYPASS_EN on an empty list, free 9 + Shift: 9 granted the same cycle.
